// File: rtl/reg_file_pkg.sv
// Shared configuration for the architectural register file.
// Holds the default ROB id width and register count, the fixed index and
// data widths, and a helper that recognises the hardwired-zero register.
// The same-cycle commit bypass on the query ports is enabled by defining
// REG_FILE_BYPASS_EN. The ROB size is 2**ROB_LOG entries; tags are compared
// by equality only, so the size itself is never needed in the logic.
package reg_file_pkg;

    localparam int DEFAULT_ROB_LOG   = 4;
    localparam int DEFAULT_REG_COUNT = 32;
    localparam int IDX_W             = 5;
    localparam int DATA_W            = 32;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // x0 reads as zero, never becomes busy and never takes a write
    function automatic logic is_x0(reg_idx_t idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational source-operand query port of the register file.
// Selects {busy, value, tag} for the queried index and masks x0 to zero.
// With REG_FILE_BYPASS_EN defined, a commit arriving this cycle that
// retires the queried register's pending producer is forwarded directly.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int ROB_LOG   = DEFAULT_ROB_LOG,
    parameter int REG_COUNT = DEFAULT_REG_COUNT
) (
    input  reg_idx_t             query,
    input  logic [REG_COUNT-1:0] busy_vec,
    input  word_t                value_arr [REG_COUNT],
    input  logic [ROB_LOG-1:0]   tag_arr   [REG_COUNT],
`ifdef REG_FILE_BYPASS_EN
    input  logic                 commit_enable,
    input  reg_idx_t             commit_index,
    input  logic [ROB_LOG-1:0]   commit_rob_id,
    input  word_t                commit_value,
`endif
    output logic                 busy,
    output word_t                value,
    output logic [ROB_LOG-1:0]   tag
);

    // Index mux with x0 masking and optional forwarding of the live commit
    always_comb begin
        busy  = 1'b0;
        value = '0;
        tag   = '0;
        if (!is_x0(query)) begin
            busy  = busy_vec[query];
            value = value_arr[query];
            tag   = tag_arr[query];
`ifdef REG_FILE_BYPASS_EN
            if (commit_enable && commit_index == query &&
                busy_vec[query] && tag_arr[query] == commit_rob_id) begin
                busy  = 1'b0;
                value = commit_value;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename-tag table.
// Commits from the ROB write values and retire matching renames, issue
// records new renames, and a flush discards every pending rename.
// Two read ports answer source-operand queries combinationally.
// Optional same-cycle commit bypass: define REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_LOG   = DEFAULT_ROB_LOG,
    parameter int REG_COUNT = DEFAULT_REG_COUNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               commit_enable,
    input  reg_idx_t           commit_index,
    input  logic [ROB_LOG-1:0] commit_rob_id,
    input  word_t              commit_value,
    input  logic               flush,
    input  logic               issue_valid,
    input  reg_idx_t           issue_dest,
    input  logic [ROB_LOG-1:0] issue_rob_id,
    input  reg_idx_t           query_rs1,
    input  reg_idx_t           query_rs2,
    output logic               rs1_busy,
    output word_t              rs1_value,
    output logic [ROB_LOG-1:0] rs1_tag,
    output logic               rs2_busy,
    output word_t              rs2_value,
    output logic [ROB_LOG-1:0] rs2_tag
);

    logic [REG_COUNT-1:0] busy;
    word_t                values [REG_COUNT];
    logic [ROB_LOG-1:0]   tags   [REG_COUNT];

    // Register state update: commit first, then flush or issue override it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_enable && !is_x0(commit_index)) begin
                values[commit_index] <= commit_value;
                if (busy[commit_index] && tags[commit_index] == commit_rob_id)
                    busy[commit_index] <= 1'b0;
            end
            if (flush) begin
                busy <= '0;
            end else if (issue_valid && !is_x0(issue_dest)) begin
                busy[issue_dest] <= 1'b1;
                tags[issue_dest] <= issue_rob_id;
            end
        end
    end

    reg_read_port #(.ROB_LOG(ROB_LOG), .REG_COUNT(REG_COUNT)) u_rs1 (
        .query         (query_rs1),
        .busy_vec      (busy),
        .value_arr     (values),
        .tag_arr       (tags),
`ifdef REG_FILE_BYPASS_EN
        .commit_enable (commit_enable),
        .commit_index  (commit_index),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
`endif
        .busy          (rs1_busy),
        .value         (rs1_value),
        .tag           (rs1_tag)
    );

    reg_read_port #(.ROB_LOG(ROB_LOG), .REG_COUNT(REG_COUNT)) u_rs2 (
        .query         (query_rs2),
        .busy_vec      (busy),
        .value_arr     (values),
        .tag_arr       (tags),
`ifdef REG_FILE_BYPASS_EN
        .commit_enable (commit_enable),
        .commit_index  (commit_index),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
`endif
        .busy          (rs2_busy),
        .value         (rs2_value),
        .tag           (rs2_tag)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the stimulus process pushes the expected
// query responses, a negedge monitor pops and compares them.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        commit_enable;
    logic [4:0]  commit_index;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [3:0]  issue_rob_id;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        rs1_busy;
    logic [31:0] rs1_value;
    logic [3:0]  rs1_tag;
    logic        rs2_busy;
    logic [31:0] rs2_value;
    logic [3:0]  rs2_tag;

    typedef struct {
        string       name;
        bit          port2;
        logic        busy;
        logic [31:0] value;
        logic [3:0]  tag;
        bit          chk_value;
        bit          chk_tag;
    } exp_t;

    exp_t exp_q[$];
    int   assertions = 0;
    int   failures   = 0;

    always #5 clk = ~clk;

    reg_file #(.ROB_LOG(4), .REG_COUNT(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .commit_enable (commit_enable),
        .commit_index  (commit_index),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_dest    (issue_dest),
        .issue_rob_id  (issue_rob_id),
        .query_rs1     (query_rs1),
        .query_rs2     (query_rs2),
        .rs1_busy      (rs1_busy),
        .rs1_value     (rs1_value),
        .rs1_tag       (rs1_tag),
        .rs2_busy      (rs2_busy),
        .rs2_value     (rs2_value),
        .rs2_tag       (rs2_tag)
    );

    // Monitor: compare every pending expectation against the query outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic        b;
            logic [31:0] v;
            logic [3:0]  t;
            e = exp_q.pop_front();
            b = e.port2 ? rs2_busy  : rs1_busy;
            v = e.port2 ? rs2_value : rs1_value;
            t = e.port2 ? rs2_tag   : rs1_tag;
            assertions++;
            if (b !== e.busy) begin
                failures++;
                $display("[TB] FAIL %s busy: got %0b want %0b", e.name, b, e.busy);
            end
            if (e.chk_value) begin
                assertions++;
                if (v !== e.value) begin
                    failures++;
                    $display("[TB] FAIL %s value: got %h want %h", e.name, v, e.value);
                end
            end
            if (e.chk_tag) begin
                assertions++;
                if (t !== e.tag) begin
                    failures++;
                    $display("[TB] FAIL %s tag: got %0d want %0d", e.name, t, e.tag);
                end
            end
        end
    end

    task automatic clear_inputs;
        rdy           = 1'b1;
        commit_enable = 1'b0;
        commit_index  = '0;
        commit_rob_id = '0;
        commit_value  = '0;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_dest    = '0;
        issue_rob_id  = '0;
    endtask

    // Let one rising edge apply the driven inputs, then return to idle
    task automatic tick;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Wait until the monitor has consumed the current expectations
    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic apply_issue(input logic [4:0] d, input logic [3:0] id);
        issue_valid  = 1'b1;
        issue_dest   = d;
        issue_rob_id = id;
    endtask

    task automatic apply_commit(input logic [4:0] idx, input logic [3:0] id,
                                input logic [31:0] val);
        commit_enable = 1'b1;
        commit_index  = idx;
        commit_rob_id = id;
        commit_value  = val;
    endtask

    task automatic expect_query(input string name, input bit port2,
                                input logic [4:0] q, input logic b,
                                input logic [31:0] v, input bit cv,
                                input logic [3:0] t, input bit ct);
        exp_t e;
        if (port2) query_rs2 = q;
        else       query_rs1 = q;
        e.name = name; e.port2 = port2; e.busy = b; e.value = v;
        e.tag = t; e.chk_value = cv; e.chk_tag = ct;
        exp_q.push_back(e);
    endtask

    initial begin
        clear_inputs();
        rst       = 1'b1;
        query_rs1 = '0;
        query_rs2 = '0;
        expect_query("reset_x1",  1'b0, 5'd1,  1'b0, 32'h0, 1, 4'd0, 1);
        expect_query("reset_x31", 1'b1, 5'd31, 1'b0, 32'h0, 1, 4'd0, 1);
        settle();
        rst = 1'b0;

        // Async reset mid-operation
        apply_issue(5'd5, 4'd3);
        tick();
        expect_query("pre_rst_x5", 1'b0, 5'd5, 1'b1, 32'h0, 1, 4'd3, 1);
        settle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_query("async_rst_x5", 1'b0, 5'd5, 1'b0, 32'h0, 1, 4'd0, 1);
        settle();
        rst = 1'b0;

        // Issue then commit
        apply_issue(5'd5, 4'd3);
        tick();
        expect_query("issue_x5", 1'b0, 5'd5, 1'b1, 32'h0, 0, 4'd3, 1);
        settle();
        apply_commit(5'd5, 4'd3, 32'hDEADBEEF);
        tick();
        expect_query("commit_x5", 1'b0, 5'd5, 1'b0, 32'hDEADBEEF, 1, 4'd0, 0);
        settle();

        // Stale commit leaves the younger rename in place
        apply_issue(5'd7, 4'd2);
        tick();
        apply_issue(5'd7, 4'd4);
        tick();
        expect_query("rename_x7", 1'b1, 5'd7, 1'b1, 32'h0, 1, 4'd4, 1);
        settle();
        apply_commit(5'd7, 4'd2, 32'h11);
        tick();
        expect_query("stale_x7", 1'b1, 5'd7, 1'b1, 32'h11, 1, 4'd4, 1);
        settle();
        apply_commit(5'd7, 4'd4, 32'h22);
        tick();
        expect_query("final_x7", 1'b1, 5'd7, 1'b0, 32'h22, 1, 4'd0, 0);
        settle();

        // Same-cycle commit and issue on x9
        apply_issue(5'd9, 4'd1);
        tick();
        apply_commit(5'd9, 4'd1, 32'h55);
        apply_issue(5'd9, 4'd6);
        tick();
        expect_query("same_cyc_x9", 1'b0, 5'd9, 1'b1, 32'h55, 1, 4'd6, 1);
        settle();

        // Flush with a concurrent commit and issue
        apply_issue(5'd3, 4'd1);
        tick();
        apply_issue(5'd4, 4'd2);
        tick();
        expect_query("busy_x3", 1'b0, 5'd3, 1'b1, 32'h0, 0, 4'd1, 1);
        expect_query("busy_x4", 1'b1, 5'd4, 1'b1, 32'h0, 0, 4'd2, 1);
        settle();
        flush = 1'b1;
        apply_commit(5'd8, 4'd0, 32'h77);
        apply_issue(5'd10, 4'd5);
        tick();
        expect_query("flush_x3", 1'b0, 5'd3, 1'b0, 32'h0, 1, 4'd0, 0);
        expect_query("flush_x4", 1'b1, 5'd4, 1'b0, 32'h0, 1, 4'd0, 0);
        settle();
        expect_query("flush_x10", 1'b0, 5'd10, 1'b0, 32'h0, 1, 4'd0, 0);
        expect_query("flush_x8",  1'b1, 5'd8,  1'b0, 32'h77, 1, 4'd0, 0);
        settle();
        expect_query("flush_x9", 1'b0, 5'd9, 1'b0, 32'h55, 1, 4'd0, 0);
        settle();

        // x0 stays zero
        apply_commit(5'd0, 4'd0, 32'hFF);
        apply_issue(5'd0, 4'd3);
        tick();
        expect_query("x0_rs1", 1'b0, 5'd0, 1'b0, 32'h0, 1, 4'd0, 1);
        expect_query("x0_rs2", 1'b1, 5'd0, 1'b0, 32'h0, 1, 4'd0, 1);
        settle();

        // rdy low freezes all state
        rdy = 1'b0;
        apply_commit(5'd2, 4'd0, 32'h99);
        apply_issue(5'd11, 4'd7);
        tick();
        expect_query("rdy_x2",  1'b0, 5'd2,  1'b0, 32'h0, 1, 4'd0, 0);
        expect_query("rdy_x11", 1'b1, 5'd11, 1'b0, 32'h0, 1, 4'd0, 0);
        settle();

        // Same-cycle commit seen by the query port before the edge
        apply_issue(5'd5, 4'd3);
        tick();
        apply_commit(5'd5, 4'd3, 32'hAB);
        #1;
`ifdef REG_FILE_BYPASS_EN
        expect_query("bypass_x5", 1'b0, 5'd5, 1'b0, 32'hAB, 1, 4'd0, 0);
`else
        expect_query("no_bypass_x5", 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1, 4'd3, 1);
`endif
        settle();
        tick();
        expect_query("after_commit_x5", 1'b0, 5'd5, 1'b0, 32'hAB, 1, 4'd0, 0);
        settle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Architectural register file with rename-tag table, the consumer end of the ROB commit interface.
- Accepts commit writes: index, ROB id and value.
- Records destination renames at issue.
- Answers the issue stage's two source-operand queries with either a committed value or the producing ROB tag.
- Clears all pending renames on a ROB-signalled flush (mispredict/jump).

Parameters:
ROB_LOG, 4, width of ROB entry id (ROB_SIZE = 2**ROB_LOG)
REG_COUNT, 32, number of architectural registers (index width fixed at 5)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; when low all state holds
commit_enable  in  1  ROB commit write strobe
commit_index  in  5  destination register of committed instr
commit_rob_id  in  ROB_LOG  ROB entry being committed
commit_value  in  32  committed result
flush  in  1  ROB jump/mispredict flag; discard all renames
issue_valid  in  1  decoder issues instr with register destination
issue_dest  in  5  destination register of issued instr
issue_rob_id  in  ROB_LOG  ROB entry allocated to issued instr
query_rs1  in  5  source register 1 index
query_rs2  in  5  source register 2 index
rs1_busy  out  1  rs1 awaits an in-flight producer
rs1_value  out  32  rs1 committed value (valid when !rs1_busy)
rs1_tag  out  ROB_LOG  producing ROB id (valid when rs1_busy)
rs2_busy / rs2_value / rs2_tag  out  1/32/ROB_LOG  same for rs2

Behaviour:
- Reset (async, rst=1):
  - All values 0, all busy bits 0, all tags 0.
  - Query outputs are combinational, so they read busy=0, value=0, tag=0.
- State per register: value[31:0], busy, tag[ROB_LOG-1:0].
- x0 is hardwired zero:
  - Never written, never busy.
  - A query of x0 returns busy=0, value=0, tag=0 regardless of inputs.
- Query ports: purely combinational reads of current state, zero latency.
- Commit, on a clock edge with rdy=1 and commit_enable=1:
  - value[idx] <= commit_value when idx!=0.
  - If busy[idx] and tag[idx]==commit_rob_id, busy[idx] <= 0.
  - If tags differ (a younger rename exists), busy and tag are untouched.
- Issue, on a clock edge with rdy=1, issue_valid=1 and flush=0:
  - When dest!=0: busy[dest] <= 1, tag[dest] <= issue_rob_id.
- Same cycle, commit and issue to the same register: the value is written, and the issue's busy=1 / new tag take priority over the commit's clear.
- Flush=1 (with rdy=1):
  - All busy bits cleared next edge; tags left stale (don't-care).
  - A commit in the same cycle still writes its value, because the ROB raises jump and commit together for JAL/JALR.
  - An issue in the same cycle is discarded.
- rdy=0: no state change; all inputs ignored; outputs still reflect current state.
- ROB id wrap-around: tags compared by equality only, no age ordering. The ROB guarantees no live id reuse.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: query outputs forward the same-cycle commit. If commit_enable && commit_index==query && query!=0 && busy && tag==commit_rob_id, output busy=0 and value=commit_value. This removes one cycle of issue stall.
- Undefined: outputs reflect registered state only. The issue stage obtains in-flight results through the ROB query path.

Decomposition:
- Shared config header holds ROB_LOG / ROB_SIZE defaults and REG_FILE_BYPASS_EN.
- Natural sub-module: reg_read_port, instantiated twice. It does the index-to-{busy,value,tag} mux, the x0 masking and the optional bypass compare.

Test Plan:
- Async reset mid-operation:
  - Issue x5 tag 3, then assert rst between clock edges.
  - Required: rs1 query of x5 immediately shows busy=0, value=0.
- Issue then commit:
  - Issue x5/tag 3; next cycle query x5 -> busy=1, tag=3.
  - Commit x5/id 3/0xDEADBEEF; following cycle -> busy=0, value=0xDEADBEEF.
- Stale commit:
  - Issue x7/tag 2, then x7/tag 4, then commit x7/id 2 value 0x11.
  - Required: value=0x11, busy=1, tag=4. Commit id 4 value 0x22 -> busy=0, value=0x22.
- Same-cycle commit+issue on x9:
  - x9 busy tag 1; commit x9/id1 0x55 together with issue x9/tag 6.
  - Required: value=0x55, busy=1, tag=6.
- Flush:
  - x3, x4 busy; assert flush with commit x8/0x77 and issue x10/tag 5.
  - Required: x3, x4, x10 not busy; x8 value=0x77.
- x0 and rdy:
  - Commit x0 0xFF, issue x0 -> x0 reads busy=0, value=0.
  - With rdy=0, commit x2 0x99 -> x2 unchanged.
  - With REG_FILE_BYPASS_EN, same-cycle commit x5/id3 0xAB returns busy=0, value=0xAB combinationally.
